// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_resp_pkg : shared widths, FSM state type and init pattern
// Rev 1.0
// ------------------------------------------------------------------
package mem_resp_pkg;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_RESP = 3'd2,
    ST_WR_BUSY = 3'd3,
    ST_INIT    = 3'd4
  } mem_resp_state_e;

  function automatic logic [LINE_W-1:0] init_line(input logic [WORD_W-1:0] idx);
    return {idx, idx + 32'd1, 32'hf0f0_0505, 32'hffff_eeee};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_line_ram.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_resp_line_ram : DEPTH x 128 line array, word write enables,
//                     registered read port (old data on same-edge write)
// Rev 1.0
// ------------------------------------------------------------------
module mem_resp_line_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WORDS_PER_LINE-1:0] wr_en,
  input  logic [LINE_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [LINE_W-1:0]         rd_data
);

  logic [LINE_W-1:0] mem_q [DEPTH];
  logic [LINE_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      if (wr_en[w]) begin
        mem_q[wr_addr][w*WORD_W +: WORD_W] <= wr_data[w*WORD_W +: WORD_W];
      end
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/mem_line_responder.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_line_responder : line memory behind the cache o_m_* port
// Option MEM_RESP_INIT_EN : after reset, fill every line with init_line(i)
// Rev 1.0
// ------------------------------------------------------------------
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH         = 128,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int LINE_ADDR_LSB = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [25:0]               i_m_addr,
  input  logic [WORDS_PER_LINE-1:0] i_m_byte_en,
  input  logic [LINE_W-1:0]         i_m_writedata,
  input  logic                      i_m_read,
  input  logic                      i_m_write,
  output logic [LINE_W-1:0]         o_m_readdata,
  output logic                      o_m_readdata_valid,
  output logic                      o_m_waitrequest
);

  localparam int AW      = $clog2(DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'((WRITE_LATENCY >= 1) ? WRITE_LATENCY - 1 : 0);

`ifdef MEM_RESP_INIT_EN
  localparam mem_resp_state_e RESET_STATE = ST_INIT;
`else
  localparam mem_resp_state_e RESET_STATE = ST_IDLE;
`endif

  mem_resp_state_e           state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]             line_idx;
  logic [AW-1:0]             ram_wr_addr;
  logic [WORDS_PER_LINE-1:0] ram_we;
  logic [WORDS_PER_LINE-1:0] ram_we_gated;
  logic [LINE_W-1:0]         ram_wr_data;
  logic                      ram_rd_en;
  logic [LINE_W-1:0]         ram_rd_data;
  logic                      unused_addr;

`ifdef MEM_RESP_INIT_EN
  logic [AW-1:0]             init_idx_q, init_idx_d;
`endif

  assign line_idx    = i_m_addr[LINE_ADDR_LSB +: AW];
  assign unused_addr = ^i_m_addr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_we      = '0;
    ram_wr_addr = line_idx;
    ram_wr_data = i_m_writedata;
    ram_rd_en   = 1'b0;
`ifdef MEM_RESP_INIT_EN
    init_idx_d  = init_idx_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // A simultaneous read stays pending behind the write.
        if (i_m_write) begin
          ram_we  = i_m_byte_en;
          cnt_d   = '0;
          state_d = (WRITE_LATENCY == 0) ? ST_IDLE : ST_WR_BUSY;
        end else if (i_m_read) begin
          ram_rd_en = 1'b1;
          cnt_d     = '0;
          state_d   = (READ_LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == RD_LAST) state_d = ST_RD_RESP;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RD_RESP: state_d = ST_IDLE;
      ST_WR_BUSY: begin
        if (cnt_q == WR_LAST) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_INIT: begin
`ifdef MEM_RESP_INIT_EN
        ram_we      = '1;
        ram_wr_addr = init_idx_q;
        ram_wr_data = init_line(32'(init_idx_q));
        if (init_idx_q == AW'(DEPTH - 1)) state_d    = ST_IDLE;
        else                              init_idx_d = init_idx_q + AW'(1);
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
`ifdef MEM_RESP_INIT_EN
      init_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`ifdef MEM_RESP_INIT_EN
      init_idx_q <= init_idx_d;
`endif
    end
  end

  // A write presented during a reset edge must not reach the array.
  assign ram_we_gated = rst ? ram_we : '0;

  mem_resp_line_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_addr (ram_wr_addr),
    .wr_en   (ram_we_gated),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (line_idx),
    .rd_data (ram_rd_data)
  );

  assign o_m_waitrequest    = (state_q != ST_IDLE);
  assign o_m_readdata_valid = (state_q == ST_RD_RESP);
  assign o_m_readdata       = o_m_readdata_valid ? ram_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
// Directed bench: main instance (DEPTH 128, RL 2, WL 1) plus a
// zero-write-latency instance (DEPTH 16, RL 1, WL 0) for back-to-back writes.
module tb_mem_line_responder;

  localparam int DEPTH  = 128;
  localparam int DEPTH0 = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic [25:0]  m_addr = '0;
  logic [3:0]   m_byte_en = '0;
  logic [127:0] m_writedata = '0;
  logic         m_read = 1'b0;
  logic         m_write = 1'b0;
  logic [127:0] m_readdata;
  logic         m_readdata_valid;
  logic         m_waitrequest;

  logic [25:0]  b_addr = '0;
  logic [3:0]   b_byte_en = '0;
  logic [127:0] b_writedata = '0;
  logic         b_read = 1'b0;
  logic         b_write = 1'b0;
  logic [127:0] b_readdata;
  logic         b_readdata_valid;
  logic         b_waitrequest;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  mem_line_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(2), .WRITE_LATENCY(1), .LINE_ADDR_LSB(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_m_addr(m_addr), .i_m_byte_en(m_byte_en), .i_m_writedata(m_writedata),
    .i_m_read(m_read), .i_m_write(m_write),
    .o_m_readdata(m_readdata), .o_m_readdata_valid(m_readdata_valid),
    .o_m_waitrequest(m_waitrequest)
  );

  mem_line_responder #(
    .DEPTH(DEPTH0), .READ_LATENCY(1), .WRITE_LATENCY(0), .LINE_ADDR_LSB(2)
  ) dut0 (
    .clk(clk), .rst(rst),
    .i_m_addr(b_addr), .i_m_byte_en(b_byte_en), .i_m_writedata(b_writedata),
    .i_m_read(b_read), .i_m_write(b_write),
    .o_m_readdata(b_readdata), .o_m_readdata_valid(b_readdata_valid),
    .o_m_waitrequest(b_waitrequest)
  );

  function automatic logic [127:0] init_pat(input int i);
    return {32'(i), 32'(i + 1), 32'hf0f0_0505, 32'hffff_eeee};
  endfunction

  function automatic logic [25:0] addr_of(input int idx);
    return 26'(idx) << 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [25:0] addr, input logic [3:0] be, input logic [127:0] d);
    int n;
    n = 0;
    m_addr = addr; m_byte_en = be; m_writedata = d; m_write = 1'b1;
    while (m_waitrequest !== 1'b0 && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL write_accept_timeout addr=%h got=timeout want=accept", addr);
    end
    tick();
    m_write = 1'b0;
  endtask

  task automatic do_read(input logic [25:0] addr, output logic [127:0] data,
                         output int lat, output int pulses, output int busy);
    int n;
    n = 0;
    m_addr = addr; m_read = 1'b1;
    while (m_waitrequest !== 1'b0 && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL read_accept_timeout addr=%h got=timeout want=accept", addr);
    end
    tick();
    m_read = 1'b0;
    lat = 0; pulses = 0; busy = 0; data = 'x;
    for (int j = 0; j < 8; j++) begin
      if (m_waitrequest === 1'b1) busy++;
      if (m_readdata_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = j + 1; data = m_readdata; end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if (m_readdata_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_valid got=%b want=0", m_readdata_valid);
    end
    vec_cnt++;
    if (m_readdata !== '0) begin
      miss_cnt++; $display("FAIL reset_readdata got=%h want=0", m_readdata);
    end
    vec_cnt++;
`ifdef MEM_RESP_INIT_EN
    if (m_waitrequest !== 1'b1) begin
      miss_cnt++; $display("FAIL reset_waitrequest got=%b want=1", m_waitrequest);
    end
`else
    if (m_waitrequest !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_waitrequest got=%b want=0", m_waitrequest);
    end
`endif
    rst = 1'b1;
    n = 0;
    while (m_waitrequest !== 1'b0 && n < 4 * DEPTH) begin tick(); n++; end
    vec_cnt++;
`ifdef MEM_RESP_INIT_EN
    if (n != DEPTH) begin
      miss_cnt++; $display("FAIL init_busy_cycles got=%0d want=%0d", n, DEPTH);
    end
`else
    if (n != 0) begin
      miss_cnt++; $display("FAIL init_busy_cycles got=%0d want=0", n);
    end
    for (int i = 0; i < 10; i++) do_write(addr_of(i), 4'hf, init_pat(i));
`endif
    n = 0;
    while (b_waitrequest !== 1'b0 && n < 4 * DEPTH0) begin tick(); n++; end
  endtask

  task automatic test_read_init();
    logic [127:0] d; int lat, pulses, busy;
    do_read(addr_of(5), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== init_pat(5)) begin
      miss_cnt++; $display("FAIL read5_data got=%h want=%h", d, init_pat(5));
    end
    vec_cnt++;
    if (lat != 2) begin miss_cnt++; $display("FAIL read5_latency got=%0d want=2", lat); end
    vec_cnt++;
    if (pulses != 1) begin miss_cnt++; $display("FAIL read5_pulses got=%0d want=1", pulses); end
    vec_cnt++;
    if (busy != 2) begin miss_cnt++; $display("FAIL read5_busy got=%0d want=2", busy); end
  endtask

  task automatic test_masked_write();
    logic [127:0] d; int lat, pulses, busy;
    logic [127:0] exp_d;
    exp_d = {32'd3, 32'hAAAA_AAAA, 32'hf0f0_0505, 32'hAAAA_AAAA};
    do_write(addr_of(3), 4'b0101, {4{32'hAAAA_AAAA}});
    do_read(addr_of(3), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== exp_d) begin
      miss_cnt++; $display("FAIL masked_write_data got=%h want=%h", d, exp_d);
    end
  endtask

  task automatic test_zero_byte_en();
    logic [127:0] d; int lat, pulses, busy;
    do_write(addr_of(4), 4'b0000, {4{32'h5555_5555}});
    vec_cnt++;
    if (m_waitrequest !== 1'b1) begin
      miss_cnt++; $display("FAIL zero_be_busy got=%b want=1", m_waitrequest);
    end
    tick();
    vec_cnt++;
    if (m_waitrequest !== 1'b0) begin
      miss_cnt++; $display("FAIL zero_be_idle got=%b want=0", m_waitrequest);
    end
    do_read(addr_of(4), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== init_pat(4)) begin
      miss_cnt++; $display("FAIL zero_be_data got=%h want=%h", d, init_pat(4));
    end
  endtask

  task automatic test_collision();
    logic [127:0] d; int lat, pulses, busy, n;
    n = 0;
    m_addr = addr_of(7); m_byte_en = 4'hf; m_writedata = {4{32'h7777_1234}};
    m_read = 1'b1; m_write = 1'b1;
    while (m_waitrequest !== 1'b0 && n < 300) begin tick(); n++; end
    tick();
    m_write = 1'b0;
    vec_cnt++;
    if (m_readdata_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL collision_early_valid got=%b want=0", m_readdata_valid);
    end
    do_read(addr_of(7), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== {4{32'h7777_1234}}) begin
      miss_cnt++; $display("FAIL collision_data got=%h want=%h", d, {4{32'h7777_1234}});
    end
    vec_cnt++;
    if (pulses != 1) begin miss_cnt++; $display("FAIL collision_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_wrap();
    logic [127:0] d; int lat, pulses, busy;
    logic [127:0] w;
    w = {32'hC0DE_0130, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D};
    do_write(26'((DEPTH + 2) * 4 + 3), 4'hf, w);
    do_read(addr_of(2), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== w) begin miss_cnt++; $display("FAIL wrap_idx2_data got=%h want=%h", d, w); end
    do_read(addr_of(3 * DEPTH + 2), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== w) begin miss_cnt++; $display("FAIL wrap_alias_data got=%h want=%h", d, w); end
  endtask

  task automatic test_back_to_back();
    vec_cnt++;
    if (b_waitrequest !== 1'b0) begin
      miss_cnt++; $display("FAIL b2b_start_idle got=%b want=0", b_waitrequest);
    end
    b_byte_en = 4'hf;
    b_write   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_addr = addr_of(i + 9); b_writedata = {4{32'hB2B0_0000 + 32'(i)}};
      tick();
      vec_cnt++;
      if (b_waitrequest !== 1'b0) begin
        miss_cnt++; $display("FAIL b2b_wait_%0d got=%b want=0", i, b_waitrequest);
      end
    end
    b_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_addr = addr_of(i + 9); b_read = 1'b1;
      tick();
      b_read = 1'b0;
      vec_cnt++;
      if (b_readdata_valid !== 1'b1 || b_readdata !== {4{32'hB2B0_0000 + 32'(i)}}) begin
        miss_cnt++;
        $display("FAIL b2b_read_%0d got=%b/%h want=1/%h", i, b_readdata_valid, b_readdata,
                 {4{32'hB2B0_0000 + 32'(i)}});
      end
      vec_cnt++;
      if (b_waitrequest !== 1'b1) begin
        miss_cnt++; $display("FAIL b2b_resp_busy_%0d got=%b want=1", i, b_waitrequest);
      end
      tick();
      vec_cnt++;
      if (b_readdata_valid !== 1'b0) begin
        miss_cnt++; $display("FAIL b2b_single_pulse_%0d got=%b want=0", i, b_readdata_valid);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [127:0] d; int lat, pulses, busy, n, seen;
    logic [127:0] exp3;
    n = 0;
    m_addr = addr_of(9); m_read = 1'b1;
    while (m_waitrequest !== 1'b0 && n < 300) begin tick(); n++; end
    tick();
    m_read = 1'b0;
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (m_readdata_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL midreset_valid got=%b want=0", m_readdata_valid);
    end
    rst = 1'b1;
    n = 0; seen = 0;
    while (m_waitrequest !== 1'b0 && n < 4 * DEPTH) begin
      if (m_readdata_valid === 1'b1) seen++;
      tick(); n++;
    end
    for (int j = 0; j < 4; j++) begin
      if (m_readdata_valid === 1'b1) seen++;
      tick();
    end
    vec_cnt++;
    if (seen != 0) begin miss_cnt++; $display("FAIL midreset_pulses got=%0d want=0", seen); end
    vec_cnt++;
`ifdef MEM_RESP_INIT_EN
    if (n != DEPTH) begin
      miss_cnt++; $display("FAIL midreset_busy got=%0d want=%0d", n, DEPTH);
    end
    exp3 = init_pat(3);
`else
    if (n != 0) begin
      miss_cnt++; $display("FAIL midreset_busy got=%0d want=0", n);
    end
    exp3 = {32'd3, 32'hAAAA_AAAA, 32'hf0f0_0505, 32'hAAAA_AAAA};
`endif
    do_read(addr_of(0), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== init_pat(0)) begin
      miss_cnt++; $display("FAIL midreset_line0 got=%h want=%h", d, init_pat(0));
    end
    do_read(addr_of(3), d, lat, pulses, busy);
    vec_cnt++;
    if (d !== exp3) begin
      miss_cnt++; $display("FAIL midreset_line3 got=%h want=%h", d, exp3);
    end
  endtask

  initial begin
    test_reset();
    test_read_init();
    test_masked_write();
    test_zero_byte_en();
    test_collision();
    test_wrap();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
